// File: rtl/stall_mem_responder.sv
// Multi-cycle data memory behind the pipeline memory stage.
// It accepts one read or write at a time. Stall stays high while the
// access is in flight, then Done pulses for one cycle with the read data
// (or, for a write, the data written). err flags illegal requests in IDLE.
//
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   Addr      - byte address; word index is Addr[ADDR_BITS:1]
//   DataIn    - write data
//   Rd, Wr    - level request strobes, exactly one may be high
//   DataOut   - read data, qualified by Done
//   Done      - one-cycle completion pulse
//   Stall     - pipeline hold (combinational in IDLE, high throughout WAIT)
//   Busy      - FSM not in IDLE
//   err       - illegal request seen in IDLE (combinational)
module stall_mem_responder #(
    parameter int unsigned ADDR_BITS = 8,
    parameter int unsigned LATENCY   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] Addr,
    input  logic [15:0] DataIn,
    input  logic        Rd,
    input  logic        Wr,
    output logic [15:0] DataOut,
    output logic        Done,
    output logic        Stall,
    output logic        Busy,
    output logic        err
);
    localparam int unsigned DW    = 16;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned DEPTH = 1 << ADDR_BITS;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [DW-1:0]        wdata_q, wdata_d;
    logic                 op_wr_q, op_wr_d;
    logic [DW-1:0]        dout_q, dout_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;

    logic [DW-1:0]        mem_q [DEPTH];

    logic                 req_any;
    logic                 illegal;
    logic                 legal;
    logic                 commit;
    logic                 acc_wr;
    logic [ADDR_BITS-1:0] acc_addr;
    logic [DW-1:0]        acc_wdata;
    logic                 mem_we;
    logic                 unused_addr;

    // Upper address bits alias onto the array and are intentionally unused.
    assign unused_addr = ^(Addr >> (ADDR_BITS + 1));

    // Request legality decode.
    always_comb begin
        req_any = Rd | Wr;
        illegal = (Rd & Wr) | (req_any & Addr[0]);
        legal   = req_any & ~illegal;
    end

    // Next-state, access and combinational handshake outputs.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        op_wr_d   = op_wr_q;
        dout_d    = dout_q;
        done_d    = 1'b0;
        busy_d    = busy_q;
        commit    = 1'b0;
        acc_wr    = op_wr_q;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        Stall     = 1'b0;
        err       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                err = illegal;
                if (legal) begin
                    Stall   = 1'b1;
                    busy_d  = 1'b1;
                    addr_d  = Addr[ADDR_BITS:1];
                    wdata_d = DataIn;
                    op_wr_d = Wr;
                    if (LATENCY == 1) begin
                        // No WAIT phase: the access uses the live request.
                        state_d   = S_DONE;
                        done_d    = 1'b1;
                        commit    = 1'b1;
                        acc_wr    = Wr;
                        acc_addr  = Addr[ADDR_BITS:1];
                        acc_wdata = DataIn;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_W'(LATENCY - 1);
                    end
                end
            end
            S_WAIT: begin
                Stall = 1'b1;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    commit  = 1'b1;
                end
            end
            S_DONE: begin
                // Requests still present here belong to the completing access.
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        if (commit) begin
            dout_d = acc_wr ? acc_wdata : mem_q[acc_addr];
        end
    end

    assign mem_we = commit & acc_wr;

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            op_wr_q <= 1'b0;
            dout_q  <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            op_wr_q <= op_wr_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    // Storage array; reset clears every word and drops any pending write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[acc_addr] <= acc_wdata;
        end
    end

    assign DataOut = dout_q;
    assign Done    = done_q;
    assign Busy    = busy_q;

endmodule

// File: tb/tb_stall_mem_responder.sv
// Scoreboard bench for stall_mem_responder: one LATENCY=4 and one LATENCY=1
// instance. The driver computes each expected response from a flat word
// array model and queues it with its due cycle; a negedge monitor pops and
// compares whenever Done is seen.
module tb_stall_mem_responder;
    localparam int unsigned AB      = 8;
    localparam int unsigned LAT_A   = 4;
    localparam int unsigned LAT_B   = 1;
    localparam int          TIMEOUT = 40;

    typedef struct {
        int          k;
        logic [15:0] data;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst   [2];
    logic [15:0] addr  [2];
    logic [15:0] din   [2];
    logic        rd    [2];
    logic        wr    [2];
    logic [15:0] dout  [2];
    logic        done  [2];
    logic        stall [2];
    logic        busy  [2];
    logic        err   [2];

    logic [15:0] mdl [2][256];
    exp_t        sb_q [$];
    int          cyc      = 0;
    int          n_checks = 0;
    int          n_pass   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    stall_mem_responder #(.ADDR_BITS(AB), .LATENCY(LAT_A)) u_dut_a (
        .clk(clk), .rst(rst[0]), .Addr(addr[0]), .DataIn(din[0]),
        .Rd(rd[0]), .Wr(wr[0]), .DataOut(dout[0]), .Done(done[0]),
        .Stall(stall[0]), .Busy(busy[0]), .err(err[0])
    );

    stall_mem_responder #(.ADDR_BITS(AB), .LATENCY(LAT_B)) u_dut_b (
        .clk(clk), .rst(rst[1]), .Addr(addr[1]), .DataIn(din[1]),
        .Rd(rd[1]), .Wr(wr[1]), .DataOut(dout[1]), .Done(done[1]),
        .Stall(stall[1]), .Busy(busy[1]), .err(err[1])
    );

    function automatic int lat_of(input int k);
        return (k == 0) ? int'(LAT_A) : int'(LAT_B);
    endfunction

    task automatic chk(input string nm, input int k, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s dut%0d cyc %0d: got 0x%04h expected 0x%04h", nm, k, cyc, act, exp);
    endtask

    task automatic chk_int(input string nm, input int k, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s dut%0d cyc %0d: got %0d expected %0d", nm, k, cyc, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Legal request: hold it until Done has been seen, then advance to the
    // next drive point with the request still applied (pipeline-like).
    task automatic do_req(input int k, input bit w, input logic [15:0] a, input logic [15:0] d);
        int          idx;
        logic [15:0] e;
        bit          got;
        exp_t        t;
        rd[k]   = ~w;
        wr[k]   = w;
        addr[k] = a;
        din[k]  = d;
        idx = int'(a[AB:1]);
        e = w ? d : mdl[k][idx];
        if (w) mdl[k][idx] = d;
        t.k = k;
        t.data = e;
        t.due = cyc + lat_of(k);
        sb_q.push_back(t);
        got = 1'b0;
        for (int i = 0; i < TIMEOUT && !got; i++) begin
            @(negedge clk);
            chk("busy", k, 16'(busy[k]), 16'(i > 0));
            if (done[k] === 1'b1) begin
                got = 1'b1;
                chk("stall_at_done", k, 16'(stall[k]), 16'(0));
            end else begin
                chk("stall_held", k, 16'(stall[k]), 16'(1));
            end
        end
        if (!got) begin
            chk("done_timeout", k, 16'(0), 16'(1));
            if (sb_q.size() > 0) sb_q.delete(sb_q.size() - 1);
        end
        tick();
    endtask

    task automatic do_illegal(input int k, input bit r, input bit w, input logic [15:0] a,
                              input logic [15:0] d, input int n);
        rd[k]   = r;
        wr[k]   = w;
        addr[k] = a;
        din[k]  = d;
        repeat (n) begin
            @(negedge clk);
            chk("err_raised", k, 16'(err[k]), 16'(1));
            chk("stall_on_err", k, 16'(stall[k]), 16'(0));
            chk("busy_on_err", k, 16'(busy[k]), 16'(0));
            tick();
        end
        rd[k] = 1'b0;
        wr[k] = 1'b0;
    endtask

    task automatic idle(input int k, input int n);
        rd[k] = 1'b0;
        wr[k] = 1'b0;
        repeat (n) begin
            @(negedge clk);
            chk("idle_stall", k, 16'(stall[k]), 16'(0));
            chk("idle_err", k, 16'(err[k]), 16'(0));
            tick();
        end
    endtask

    task automatic chk_all_zero(input int k, input string tag);
        chk({tag, "_dout"},  k, dout[k], 16'h0000);
        chk({tag, "_done"},  k, 16'(done[k]), 16'(0));
        chk({tag, "_stall"}, k, 16'(stall[k]), 16'(0));
        chk({tag, "_busy"},  k, 16'(busy[k]), 16'(0));
        chk({tag, "_err"},   k, 16'(err[k]), 16'(0));
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            if (done[k] === 1'b1) begin
                chk("done_stall_overlap", k, 16'(stall[k]), 16'(0));
                if (sb_q.size() == 0 || sb_q[0].k != k) begin
                    chk("unexpected_done", k, 16'(1), 16'(0));
                end else begin
                    e = sb_q.pop_front();
                    chk("dataout", k, dout[k], e.data);
                    chk_int("done_cycle", k, cyc, e.due);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] a;
        bit          r;
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1; rd[k] = 1'b0; wr[k] = 1'b0;
            addr[k] = 16'h0000; din[k] = 16'h0000;
            for (int i = 0; i < 256; i++) mdl[k][i] = 16'h0000;
        end
        repeat (2) @(posedge clk);
        #1;
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        @(negedge clk);
        chk_all_zero(0, "reset");
        chk_all_zero(1, "reset");
        tick();

        // Reset then read, then write/read-back at the same word.
        do_req(0, 1'b0, 16'h0010, 16'h0000);
        do_req(0, 1'b1, 16'h0020, 16'hBEEF);
        do_req(0, 1'b0, 16'h0020, 16'h0000);
        idle(0, 1);

        // Illegal requests leave the array alone.
        do_req(0, 1'b1, 16'h0004, 16'h7777);
        idle(0, 1);
        do_illegal(0, 1'b1, 1'b1, 16'h0004, 16'hDEAD, 3);
        do_illegal(0, 1'b1, 1'b0, 16'h0003, 16'h0000, 3);
        do_illegal(0, 1'b0, 1'b1, 16'h0005, 16'h4321, 2);
        idle(0, 1);
        do_req(0, 1'b0, 16'h0004, 16'h0000);

        // Request held through DONE: re-accepted only on the following cycle.
        do_req(0, 1'b1, 16'h0040, 16'h1234);
        do_req(0, 1'b1, 16'h0040, 16'h1234);
        idle(0, 2);

        // Randomized traffic with aliasing upper bits and occasional illegal requests.
        for (int t = 0; t < 40; t++) begin
            a = 16'($urandom);
            a[AB:1] = 8'($urandom_range(0, 15));
            a[0] = 1'b0;
            if ($urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 1) == 0) begin
                    do_illegal(0, 1'b1, 1'b1, a, 16'($urandom), 2);
                end else begin
                    r = 1'($urandom_range(0, 1));
                    a[0] = 1'b1;
                    do_illegal(0, r, ~r, a, 16'($urandom), 2);
                end
            end else begin
                do_req(0, 1'($urandom_range(0, 1)), a, 16'($urandom));
            end
            if ($urandom_range(0, 2) == 0) idle(0, 1);
        end
        do_req(0, 1'b1, 16'h0002, 16'hC0DE);
        idle(0, 1);

        // Reset in the second WAIT cycle discards the pending write.
        rd[0] = 1'b0; wr[0] = 1'b1; addr[0] = 16'h0050; din[0] = 16'hAAAA;
        @(negedge clk);
        chk("stall_issue", 0, 16'(stall[0]), 16'(1));
        tick();
        tick();
        rst[0] = 1'b1;
        wr[0] = 1'b0;
        tick();
        rst[0] = 1'b0;
        @(negedge clk);
        chk_all_zero(0, "midreset");
        for (int i = 0; i < 256; i++) mdl[0][i] = 16'h0000;
        tick();
        do_req(0, 1'b0, 16'h0050, 16'h0000);
        do_req(0, 1'b0, 16'h0020, 16'h0000);
        idle(0, 2);

        // LATENCY=1 instance.
        do_req(1, 1'b1, 16'h0020, 16'h5A5A);
        idle(1, 1);
        do_req(1, 1'b0, 16'h0020, 16'h0000);
        do_req(1, 1'b1, 16'h0022, 16'h0F0F);
        do_req(1, 1'b0, 16'h0022, 16'h0000);
        do_illegal(1, 1'b1, 1'b1, 16'h0020, 16'hFFFF, 2);
        do_req(1, 1'b0, 16'h0020, 16'h0000);
        for (int t = 0; t < 12; t++) begin
            a = 16'($urandom);
            a[AB:1] = 8'($urandom_range(16, 23));
            a[0] = 1'b0;
            do_req(1, 1'($urandom_range(0, 1)), a, 16'($urandom));
        end
        idle(1, 3);
        idle(0, 1);

        chk_int("scoreboard_empty", 0, sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
